// File: rtl/arb_req_queue.sv
// -----------------------------------------------------------------------------
// arb_req_queue
//   Order-preserving FIFO that sits behind a two-way request arbiter. Each
//   entry holds {bits_valid, addr[26:0], chosen} (29 bits). Storage is a small
//   register array addressed by wrap-around write/read pointers; occupancy is
//   tracked in a separate counter so full/empty need no extra pointer bit.
//
//   Optional feature (macro ARB_REQ_QUEUE_FLOW_EN):
//     defined   - when empty, an incoming request is presented on io_deq_*
//                 in the same cycle; if taken there it is never stored.
//     undefined - no combinational enq->deq path; one cycle of latency.
//
// Parameters
//   ENTRIES               queue depth, power of two, 2..16
//
// Ports
//   clock                 single clock, rising edge
//   reset                 synchronous, active-high
//   io_enq_valid          upstream request valid
//   io_enq_ready          queue not full
//   io_enq_bits_valid     payload valid flag
//   io_enq_bits_bits_addr request address (27 bits)
//   io_enq_chosen         arbiter grant index
//   io_deq_valid          head entry available
//   io_deq_ready          downstream accepts head
//   io_deq_bits_valid     head payload valid flag
//   io_deq_bits_bits_addr head address
//   io_deq_chosen         head grant index
//   io_count              occupancy, 0..ENTRIES
// -----------------------------------------------------------------------------
module arb_req_queue #(
    parameter int ENTRIES = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        io_enq_valid,
    output logic                        io_enq_ready,
    input  logic                        io_enq_bits_valid,
    input  logic [26:0]                 io_enq_bits_bits_addr,
    input  logic                        io_enq_chosen,
    output logic                        io_deq_valid,
    input  logic                        io_deq_ready,
    output logic                        io_deq_bits_valid,
    output logic [26:0]                 io_deq_bits_bits_addr,
    output logic                        io_deq_chosen,
    output logic [$clog2(ENTRIES):0]    io_count
);

    localparam int PW = $clog2(ENTRIES);
    localparam int CW = PW + 1;
    localparam int EW = 29;

    logic [EW-1:0] mem_q [ENTRIES];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          empty;
    logic          full;
    logic          flow;
    logic          enq_fire;
    logic          deq_fire;
    logic          do_write;
    logic          do_read;
    logic [EW-1:0] enq_entry;
    logic [EW-1:0] head_entry;
    logic [EW-1:0] deq_entry;

    assign enq_entry  = {io_enq_bits_valid, io_enq_bits_bits_addr, io_enq_chosen};
    assign head_entry = mem_q[rd_ptr_q];

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(ENTRIES));

    assign io_enq_ready = !full;
    assign io_count     = count_q;

`ifdef ARB_REQ_QUEUE_FLOW_EN
    // Empty queue bypass: the arriving request is the head this cycle.
    assign flow         = empty && io_enq_valid;
    assign io_deq_valid = !empty || io_enq_valid;
    assign deq_entry    = flow ? enq_entry : head_entry;
`else
    assign flow         = 1'b0;
    assign io_deq_valid = !empty;
    assign deq_entry    = head_entry;
`endif

    assign {io_deq_bits_valid, io_deq_bits_bits_addr, io_deq_chosen} = deq_entry;

    assign enq_fire = io_enq_valid && io_enq_ready;
    assign deq_fire = io_deq_valid && io_deq_ready;

    // A bypassed request taken downstream never touches storage or pointers.
    assign do_write = enq_fire && !(flow && io_deq_ready);
    assign do_read  = deq_fire && !flow;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_read) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_write, do_read})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not cleared by reset; the pointers alone define contents.
    always_ff @(posedge clock) begin
        if (do_write && !reset) begin
            mem_q[wr_ptr_q] <= enq_entry;
        end
    end

endmodule
